// File: rtl/mux_sched_pkg.sv
// Shared types and sizing helpers for the round-robin mux scheduler.
// Both the top level and the priority encoder import this package.
package mux_sched_pkg;

   typedef enum logic {IDLE, BUSY} sched_state_t;

   localparam int DEFAULT_N = 8;

   function automatic int idx_width(input int n);
      return (n > 2) ? $clog2(n) : 1;
   endfunction

   localparam int DEFAULT_IW = idx_width(DEFAULT_N);

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority encoder: returns the first asserted request found when
// scanning ptr, ptr+1, ... modulo N.
module rr_pick
   import mux_sched_pkg::*;
#(
   parameter int N  = DEFAULT_N,
   parameter int IW = idx_width(N)
)
(
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [IW-1:0] idx,
   output logic          found
);

   logic [IW-1:0] w_cand [N];
   logic [N-1:0]  w_hit;

   // w_cand[gi] is the requester index sitting gi places after ptr
   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_off
         logic [IW:0] w_sum;
         assign w_sum       = {1'b0, ptr} + (IW+1)'(gi);
         assign w_cand[gi]  = (w_sum >= (IW+1)'(N)) ? IW'(w_sum - (IW+1)'(N)) : IW'(w_sum);
         assign w_hit[gi]   = req[w_cand[gi]];
      end
   endgenerate

   always_comb begin
      idx   = '0;
      found = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (w_hit[k]) begin
            idx   = w_cand[k];
            found = 1'b1;
         end
      end
   end

endmodule

// File: rtl/mux_rr_scheduler.sv
// Round-robin scheduler sharing one N:1 mux output among N requesters, with
// a valid/ready downstream handshake and a per-grant transfer quantum.
module mux_rr_scheduler
   import mux_sched_pkg::*;
#(
   parameter int N       = 8,
   parameter int W       = 1,
   parameter int QUANTUM = 4
)
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic [N-1:0]          req,
   input  logic [N*W-1:0]        x,
   output logic [$clog2(N)-1:0]  ss,
   output logic [N-1:0]          gnt,
   output logic [W-1:0]          y,
   output logic                  y_valid,
   input  logic                  y_ready,
   output logic [N-1:0]          ack
);

   localparam int IW = $clog2(N);
   localparam int CW = (QUANTUM > 1) ? $clog2(QUANTUM) : 1;

   sched_state_t  r_state;
   logic [IW-1:0] r_ptr;
   logic [IW-1:0] r_ss;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_gnt;

   logic [W-1:0]  w_x [N];
   logic [IW-1:0] w_pick_idx;
   logic          w_pick_found;
   logic          w_xfer;
   logic          w_last;
   logic          w_release;
   logic [IW-1:0] w_ptr_next;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_unpack
         assign w_x[gi] = x[gi*W +: W];
      end
   endgenerate

   rr_pick #(
      .N  (N),
      .IW (IW)
   ) u_pick (
      .req   (req),
      .ptr   (r_ptr),
      .idx   (w_pick_idx),
      .found (w_pick_found)
   );

   assign y       = w_x[r_ss];
   // Reset abandons any handshake in flight, so no valid/ack while it is high
   assign y_valid = ~reset & (r_state == BUSY) & req[r_ss];
   assign w_xfer  = y_valid & y_ready;
   assign ack     = w_xfer ? r_gnt : '0;
   assign ss      = r_ss;
   assign gnt     = r_gnt;

   assign w_last     = (r_cnt == CW'(QUANTUM - 1));
   assign w_release  = (r_state == BUSY) & (w_xfer ? w_last : ~req[r_ss]);
   assign w_ptr_next = (r_ss == IW'(N - 1)) ? '0 : r_ss + IW'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= IDLE;
         r_ptr   <= '0;
         r_ss    <= '0;
         r_cnt   <= '0;
         r_gnt   <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_pick_found) begin
                  r_ss    <= w_pick_idx;
                  r_cnt   <= '0;
                  r_gnt   <= N'(1) << w_pick_idx;
                  r_state <= BUSY;
               end
            end
            BUSY: begin
               // Every release passes through IDLE, giving one bubble cycle
               if (w_release) begin
                  r_ptr   <= w_ptr_next;
                  r_gnt   <= '0;
                  r_state <= IDLE;
               end else if (w_xfer) begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

endmodule
